imem_boot_loader: RTL and testbench

- Writer side of the instruction-memory interface: receives a framed byte stream over a valid/ready handshake and assembles it into 16-bit instruction words.
- Writes each word into instruction memory at byte addresses stepping by 2, matching the PC's +2 increment.
- Holds the pipeline in reset until a frame is loaded and its checksum passes.
- Sits between the host byte link and the instruction memory write port, alongside the CPU top level.

---
 rtl/imem_boot_loader_if.sv | 23 ++
 rtl/imem_boot_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-link and instruction-memory write signals of the boot loader.
//   byte_valid/byte_data/byte_ready : host byte stream, valid/ready handshake
//   imem_we/imem_addr/imem_wdata    : instruction-memory write port
// The master modport is the environment (byte source, memory); the slave
// modport is the loader itself.
interface imem_boot_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: receives a framed byte stream
// (LEN_HI, LEN_LO, N x {HI, LO}, CHK), writes each 16-bit word to
// instruction memory at byte addresses BASE_ADDR, +2, +4, ... and keeps
// the CPU in reset until a frame with a zero 8-bit byte sum has loaded.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   start         : single-cycle pulse arming the loader for a new frame
//   link          : byte stream in + instruction-memory write port out
//   cpu_hold      : high keeps the CPU in reset
//   busy          : frame in progress
//   done / error  : sticky frame-accepted / frame-rejected flags
//   words_loaded  : words written in the current frame
module imem_boot_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_boot_loader_if.slave   link,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         words_loaded
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [3:0] {
    IDLE, LEN_H, LEN_L, W_HI, W_LO, WRITE, CHK, DONE, ERR
  } state_t;

  state_t              state, state_n;
  logic [WORD_W-1:0]   len_q, len_n;
  logic [BYTE_W-1:0]   acc_q, acc_n;
  logic [WORD_W-1:0]   addr_q, addr_n;
  logic [WORD_W-1:0]   wdata_q, wdata_n;
  logic                byte_ready_q, byte_ready_n;
  logic                imem_we_q, imem_we_n;
  logic                cpu_hold_n, busy_n, done_n, error_n;
  logic [WORD_W-1:0]   words_n;
  logic                xfer;
  logic                arm;
  logic [BYTE_W-1:0]   acc_sum;
  logic [WORD_W-1:0]   len_full;
  logic [WORD_W-1:0]   words_inc;

  assign link.byte_ready = byte_ready_q;
  assign link.imem_we    = imem_we_q;
  assign link.imem_addr  = addr_q;
  assign link.imem_wdata = wdata_q;

  // A byte moves only when the registered ready meets the source's valid.
  assign xfer      = link.byte_valid && byte_ready_q;
  assign acc_sum   = BYTE_W'(acc_q + link.byte_data);
  assign len_full  = {len_q[WORD_W-1:BYTE_W], link.byte_data};
  assign words_inc = WORD_W'(words_loaded + 16'd1);

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      len_q        <= '0;
      acc_q        <= '0;
      addr_q       <= BASE_ADDR;
      wdata_q      <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      cpu_hold     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state        <= state_n;
      len_q        <= len_n;
      acc_q        <= acc_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      byte_ready_q <= byte_ready_n;
      imem_we_q    <= imem_we_n;
      cpu_hold     <= cpu_hold_n;
      busy         <= busy_n;
      done         <= done_n;
      error        <= error_n;
      words_loaded <= words_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    len_n      = len_q;
    acc_n      = acc_q;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    cpu_hold_n = cpu_hold;
    busy_n     = busy;
    done_n     = done;
    error_n    = error;
    words_n    = words_loaded;
    arm        = 1'b0;

    case (state)
      IDLE: arm = start;

      LEN_H: if (xfer) begin
        len_n[WORD_W-1:BYTE_W] = link.byte_data;
        acc_n   = acc_sum;
        state_n = LEN_L;
      end

      LEN_L: if (xfer) begin
        len_n = len_full;
        acc_n = acc_sum;
        if (32'(len_full) > MAX_WORDS) state_n = ERR;
        else if (len_full == '0)       state_n = CHK;
        else                           state_n = W_HI;
      end

      W_HI: if (xfer) begin
        wdata_n[WORD_W-1:BYTE_W] = link.byte_data;
        acc_n   = acc_sum;
        state_n = W_LO;
      end

      W_LO: if (xfer) begin
        wdata_n[BYTE_W-1:0] = link.byte_data;
        acc_n   = acc_sum;
        state_n = WRITE;
      end

      // Strobe cycle; address and count advance as the state is left.
      WRITE: begin
        addr_n  = WORD_W'(addr_q + 16'd2);
        words_n = words_inc;
        state_n = (words_inc == len_q) ? CHK : W_HI;
      end

      CHK: if (xfer) begin
        acc_n   = acc_sum;
        state_n = (acc_sum == '0) ? DONE : ERR;
      end

      // Flags settle one cycle after the terminal state is entered.
      DONE: begin
        busy_n     = 1'b0;
        done_n     = 1'b1;
        cpu_hold_n = 1'b0;
        arm        = start;
      end

      ERR: begin
        busy_n     = 1'b0;
        error_n    = 1'b1;
        cpu_hold_n = 1'b1;
        arm        = start;
      end

      default: state_n = IDLE;
    endcase

    // Arming overrides the terminal-state flag updates above.
    if (arm) begin
      state_n    = LEN_H;
      busy_n     = 1'b1;
      done_n     = 1'b0;
      error_n    = 1'b0;
      words_n    = '0;
      addr_n     = BASE_ADDR;
      acc_n      = '0;
      cpu_hold_n = 1'b1;
    end

    // Ready and strobe follow the state being entered, so WRITE never
    // accepts a byte and the strobe lands in the cycle after the LO byte.
    byte_ready_n = (state_n == LEN_H) || (state_n == LEN_L) ||
                   (state_n == W_HI)  || (state_n == W_LO)  ||
                   (state_n == CHK);
    imem_we_n    = (state_n == WRITE);
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good/bad checksum frames, oversize
// and zero-length headers, a stalled 4-word frame, reset and restart.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        cpu_hold, busy, done, error;
  logic [15:0] words_loaded;

  int checks = 0;
  int failures = 0;

  // Write log filled by the monitor only.
  logic [15:0] wr_addr [64];
  logic [15:0] wr_data [64];
  int n_writes = 0;
  int ready_viol = 0;
  int both_viol = 0;

  imem_boot_loader_if bus ();

  imem_boot_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .link(bus),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_addr[n_writes % 64] <= bus.imem_addr;
      wr_data[n_writes % 64] <= bus.imem_wdata;
      n_writes <= n_writes + 1;
      if (bus.byte_ready) ready_viol <= ready_viol + 1;
    end
    if (done && error) both_viol <= both_viol + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.byte_ready) begin
      checks++; failures++;
      $display("FAIL send_byte_timeout byte=%h ready=%b required=1", b, bus.byte_ready);
    end else begin
      tick();
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_byte_gap(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) tick();
    send_byte(b);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++; if (bus.byte_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.byte_ready); end
    checks++; if (bus.imem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.imem_we); end
    checks++; if (bus.imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", bus.imem_addr); end
    checks++; if ({cpu_hold, busy, done, error} !== 4'b1000) begin failures++; $display("FAIL reset_flags got=%b exp=1000", {cpu_hold, busy, done, error}); end
    checks++; if (words_loaded !== 16'd0) begin failures++; $display("FAIL reset_words got=%0d exp=0", words_loaded); end
    rst = 1'b1;
    tick();
    checks++; if (bus.byte_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_quiet ready=%b busy=%b exp=0/0", bus.byte_ready, busy); end
  endtask

  // 00 02 12 34 AB CD: byte sum 0xC0, so CHK=0x40 closes the frame to 0.
  task automatic test_load_two();
    int base;
    base = n_writes;
    pulse_start();
    checks++; if ({busy, cpu_hold, bus.byte_ready} !== 3'b111) begin failures++; $display("FAIL arm_flags got=%b exp=111", {busy, cpu_hold, bus.byte_ready}); end
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 16'h0000 || bus.imem_wdata !== 16'h1234) begin failures++; $display("FAIL write0_latency we=%b addr=%h data=%h exp=1/0000/1234", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
    send_byte(8'hAB); send_byte(8'hCD);
    checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 16'h0002 || bus.imem_wdata !== 16'hABCD) begin failures++; $display("FAIL write1_latency we=%b addr=%h data=%h exp=1/0002/abcd", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
    send_byte(8'h40);
    checks++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin failures++; $display("FAIL done_entry done=%b hold=%b exp=0/1", done, cpu_hold); end
    tick();
    checks++; if ({done, error, busy, cpu_hold} !== 4'b1000) begin failures++; $display("FAIL load2_flags got=%b exp=1000", {done, error, busy, cpu_hold}); end
    checks++; if (words_loaded !== 16'd2) begin failures++; $display("FAIL load2_words got=%0d exp=2", words_loaded); end
    checks++; if (n_writes - base !== 2) begin failures++; $display("FAIL load2_nwrites got=%0d exp=2", n_writes - base); end
    checks++; if (wr_addr[base % 64] !== 16'h0000 || wr_data[base % 64] !== 16'h1234) begin failures++; $display("FAIL load2_w0 got=%h/%h exp=0000/1234", wr_addr[base % 64], wr_data[base % 64]); end
    checks++; if (wr_addr[(base + 1) % 64] !== 16'h0002 || wr_data[(base + 1) % 64] !== 16'hABCD) begin failures++; $display("FAIL load2_w1 got=%h/%h exp=0002/abcd", wr_addr[(base + 1) % 64], wr_data[(base + 1) % 64]); end
  endtask

  task automatic test_bad_checksum();
    int base;
    base = n_writes;
    pulse_start();
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rearm hold=%b done=%b busy=%b exp=1/0/1", cpu_hold, done, busy); end
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h41);
    tick();
    checks++; if ({error, done, cpu_hold, busy} !== 4'b1010) begin failures++; $display("FAIL badchk_flags got=%b exp=1010", {error, done, cpu_hold, busy}); end
    checks++; if (n_writes - base !== 2) begin failures++; $display("FAIL badchk_nwrites got=%0d exp=2", n_writes - base); end
  endtask

  task automatic test_oversize();
    int base;
    int ready_seen;
    base = n_writes;
    ready_seen = 0;
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    checks++; if (bus.byte_ready !== 1'b0) begin failures++; $display("FAIL oversize_ready got=%b exp=0", bus.byte_ready); end
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    repeat (4) begin
      tick();
      if (bus.byte_ready !== 1'b0) ready_seen++;
    end
    bus.byte_valid = 1'b0;
    checks++; if (ready_seen !== 0) begin failures++; $display("FAIL oversize_third_byte ready_cycles=%0d exp=0", ready_seen); end
    checks++; if ({error, done, cpu_hold, busy} !== 4'b1010) begin failures++; $display("FAIL oversize_flags got=%b exp=1010", {error, done, cpu_hold, busy}); end
    checks++; if (n_writes - base !== 0 || words_loaded !== 16'd0) begin failures++; $display("FAIL oversize_writes n=%0d words=%0d exp=0/0", n_writes - base, words_loaded); end
  endtask

  task automatic test_zero_length();
    int base;
    base = n_writes;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    tick();
    checks++; if ({done, error, cpu_hold} !== 3'b100) begin failures++; $display("FAIL zero_flags got=%b exp=100", {done, error, cpu_hold}); end
    checks++; if (n_writes - base !== 0 || words_loaded !== 16'd0) begin failures++; $display("FAIL zero_writes n=%0d words=%0d exp=0/0", n_writes - base, words_loaded); end
  endtask

  // Words 0102 0304 0506 0708: byte sum 0x28, CHK=0xD8.
  task automatic test_back_to_back_stall();
    int base;
    int viol0;
    logic [7:0]  frame [11];
    logic [15:0] exp_data [4];
    frame = '{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hD8};
    exp_data = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    base  = n_writes;
    viol0 = ready_viol;
    pulse_start();
    for (int i = 0; i < 11; i++) send_byte_gap(frame[i]);
    tick();
    checks++; if ({done, error} !== 2'b10 || words_loaded !== 16'd4) begin failures++; $display("FAIL stall_done de=%b words=%0d exp=10/4", {done, error}, words_loaded); end
    checks++; if (n_writes - base !== 4) begin failures++; $display("FAIL stall_nwrites got=%0d exp=4", n_writes - base); end
    checks++; if (ready_viol - viol0 !== 0) begin failures++; $display("FAIL stall_ready_in_write got=%0d exp=0", ready_viol - viol0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[(base + i) % 64] !== 16'(2 * i) || wr_data[(base + i) % 64] !== exp_data[i]) begin
        failures++;
        $display("FAIL stall_write%0d got=%h/%h exp=%h/%h", i, wr_addr[(base + i) % 64], wr_data[(base + i) % 64], 16'(2 * i), exp_data[i]);
      end
    end
  endtask

  task automatic test_reset_restart();
    int base;
    base = n_writes;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
    #2 rst = 1'b0;
    #1;
    checks++; if ({bus.byte_ready, bus.imem_we, cpu_hold, busy, done, error} !== 6'b001000) begin failures++; $display("FAIL midreset_flags got=%b exp=001000", {bus.byte_ready, bus.imem_we, cpu_hold, busy, done, error}); end
    checks++; if (bus.imem_addr !== 16'h0000 || bus.imem_wdata !== 16'h0000 || words_loaded !== 16'd0) begin failures++; $display("FAIL midreset_data addr=%h data=%h words=%0d exp=0000/0000/0", bus.imem_addr, bus.imem_wdata, words_loaded); end
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    checks++; if (n_writes - base !== 0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_nowrite n=%0d busy=%b exp=0/0", n_writes - base, busy); end

    // start mid-frame must not restart; CHK = -(01+12+34) = B9.
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    pulse_start();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hB9);
    tick();
    checks++; if ({done, error} !== 2'b10 || words_loaded !== 16'd1) begin failures++; $display("FAIL busy_start_ignored de=%b words=%0d exp=10/1", {done, error}, words_loaded); end
    checks++; if (n_writes - base !== 1 || wr_addr[base % 64] !== 16'h0000 || wr_data[base % 64] !== 16'h1234) begin failures++; $display("FAIL busy_start_write n=%0d got=%h/%h exp=1 0000/1234", n_writes - base, wr_addr[base % 64], wr_data[base % 64]); end

    // Restart after DONE; CHK = -(01+AB+CD) = 87.
    pulse_start();
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL restart_hold hold=%b done=%b busy=%b exp=1/0/1", cpu_hold, done, busy); end
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h87);
    tick();
    checks++; if ({done, cpu_hold} !== 2'b10 || n_writes - base !== 2) begin failures++; $display("FAIL restart_done dh=%b n=%0d exp=10/2", {done, cpu_hold}, n_writes - base); end
    checks++; if (wr_addr[(base + 1) % 64] !== 16'h0000 || wr_data[(base + 1) % 64] !== 16'hABCD) begin failures++; $display("FAIL restart_write got=%h/%h exp=0000/abcd", wr_addr[(base + 1) % 64], wr_data[(base + 1) % 64]); end
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    test_reset();
    test_load_two();
    test_bad_checksum();
    test_oversize();
    test_zero_length();
    test_back_to_back_stall();
    test_reset_restart();
    tick();
    checks++; if (both_viol !== 0) begin failures++; $display("FAIL done_and_error cycles=%0d exp=0", both_viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
